onehot_grant_decoder: RTL and testbench
=======================================

Name: onehot_grant_decoder

Overview:
Opposite end of the 8-to-3 priority encoder path. Accepts an encoded index (0..7) over a valid/ready handshake and expands it into a registered one-hot strobe. The strobe is held for a fixed number of cycles, then a fixed number of idle cycles follows before the next index is accepted. It sits downstream of the priority encoder and drives per-line grant/enable signals.

Parameters:
N_OUT, 8, number of one-hot output lines; 2..2**IDX_W.
IDX_W, 3, encoded index width.
HOLD_CYCLES, 4, cycles out_onehot stays asserted per grant; must be >= 1.
GAP_CYCLES, 1, cycles of all-zero output after each hold before in_ready returns; may be 0.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  index present on in_idx.
in_idx  input  IDX_W  encoded index to decode.
in_ready  output  1  block can accept an index this cycle.
out_onehot  output  N_OUT  registered one-hot grant; bit in_idx set.
out_valid  output  1  high while out_onehot is non-zero (HOLD state).
busy  output  1  high in HOLD or GAP.
idx_err  output  1  one-cycle pulse: accepted index >= N_OUT.

Behaviour:
- Interface: one clock `clk`; reset `rst`, synchronous, active-high. Reset is sampled only on the rising edge of clk.
- Reset values: state=IDLE, out_onehot=0, out_valid=0, busy=0, idx_err=0, in_ready=1 (in_ready is decoded from state). Counter=0.
- FSM states: IDLE, HOLD, GAP. All outputs are registered except in_ready (= state==IDLE).
- IDLE:
  - Accept occurs when in_valid && in_ready.
  - Valid index: on the next edge, out_onehot = 1<<in_idx, out_valid=1, busy=1, counter = HOLD_CYCLES-1, and state moves to HOLD.
  - Latency from accept edge to output is 1 cycle.
  - Index >= N_OUT: the index is consumed, idx_err=1 for exactly one cycle, outputs stay zero, and state stays IDLE.
  - When N_OUT == 2**IDX_W, idx_err never fires.
- HOLD:
  - out_onehot is stable for exactly HOLD_CYCLES cycles.
  - When counter==0, the next edge clears out_onehot and out_valid. The FSM then goes to GAP with counter = GAP_CYCLES-1, or directly to IDLE if GAP_CYCLES==0.
  - Otherwise the counter decrements.
- GAP: outputs are zero and busy=1. When counter==0, the next edge returns the FSM to IDLE (busy=0).
- Throughput: one grant per HOLD_CYCLES+GAP_CYCLES+1 cycles at best. For the defaults (4,1) that is one grant every 6 cycles.
- in_valid / in_idx are ignored outside IDLE. The upstream must hold them until in_ready.
- The counter is $clog2(max(HOLD_CYCLES,GAP_CYCLES,2)) bits wide and never wraps; it saturates at 0 by construction.
- rst asserted mid-HOLD/GAP: the next edge forces the reset values. A pending grant is dropped, not completed.
- out_onehot is always zero or exactly one bit set. It is never multi-hot.

Optional Feature:
DEC_ACK_EN: adds input port out_ack (1 bit).
- With the macro: in HOLD, out_ack=1 on an edge ends the hold at that edge, with the same transition as counter==0.
- out_ack is ignored in IDLE and GAP.
- Without the macro: the port is absent and the hold always runs the full HOLD_CYCLES.

Test Plan:
- Reset, then idle: rst=1 for 2 cycles -> out_onehot=8'h00, out_valid=0, in_ready=1, busy=0, idx_err=0.
- Single grant: in_idx=3'd5 accepted at edge T -> out_onehot=8'b0010_0000 at T+1..T+4, 0 at T+5 (GAP), in_ready=1 again from T+6.
- Sweep: in_idx 0..7 back-to-back with in_valid held -> out_onehot 8'h01,02,04,...,80 in order, each for 4 cycles, 6-cycle spacing, none lost.
- Back-pressure: in_valid=1, in_idx=3'd2 driven during HOLD of the previous grant -> in_ready=0; 3'd2 is accepted only in IDLE and decodes to 8'h04.
- Range error (N_OUT=6): in_idx=3'd7 -> idx_err=1 for one cycle, out_onehot stays 0, in_ready stays 1.
- Reset mid-hold: rst=1 two cycles into HOLD of idx 4 -> next edge out_onehot=0, state IDLE. With DEC_ACK_EN, out_ack at HOLD cycle 2 -> out_onehot clears the following cycle.

Source files
------------

// File: rtl/onehot_grant_decoder_if.sv
// Handshake bundle between the encoder side and onehot_grant_decoder.
// Optional out_ack line exists only when DEC_ACK_EN is defined.
interface onehot_grant_decoder_if #(
   parameter int N_OUT = 8,
   parameter int IDX_W = 3
);
   logic             in_valid;
   logic [IDX_W-1:0] in_idx;
   logic             in_ready;
   logic [N_OUT-1:0] out_onehot;
   logic             out_valid;
   logic             busy;
   logic             idx_err;
`ifdef DEC_ACK_EN
   logic             out_ack;

   modport master (
      output in_valid, in_idx, out_ack,
      input  in_ready, out_onehot, out_valid,
      input  busy, idx_err
   );
   modport slave (
      input  in_valid, in_idx, out_ack,
      output in_ready, out_onehot, out_valid,
      output busy, idx_err
   );
`else
   modport master (
      output in_valid, in_idx,
      input  in_ready, out_onehot, out_valid,
      input  busy, idx_err
   );
   modport slave (
      input  in_valid, in_idx,
      output in_ready, out_onehot, out_valid,
      output busy, idx_err
   );
`endif
endinterface

// File: rtl/onehot_grant_decoder.sv
// Index-to-one-hot grant expander with fixed hold and idle gap.
// Define DEC_ACK_EN to let out_ack end a hold early.
module onehot_grant_decoder #(
   parameter int N_OUT       = 8,
   parameter int IDX_W       = 3,
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 1
) (
   input  logic clk,
   input  logic rst,
   onehot_grant_decoder_if.slave bus
);
   localparam int MAXC =
      (HOLD_CYCLES > GAP_CYCLES) ?
      ((HOLD_CYCLES > 2) ? HOLD_CYCLES : 2) :
      ((GAP_CYCLES > 2) ? GAP_CYCLES : 2);
   localparam int CW = $clog2(MAXC);
   localparam logic [CW-1:0] HOLD_LD =
      CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD =
      CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [IDX_W:0] N_LIM =
      (IDX_W + 1)'(N_OUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [N_OUT-1:0] onehot_q;
   logic [N_OUT-1:0] onehot_d;
   logic             valid_q;
   logic             busy_q;
   logic             err_q;
   logic             idx_ok;
   logic             hold_end;

   always_comb begin
      onehot_d = '0;
      for (int i = 0; i < N_OUT; i++)
         onehot_d[i] = (bus.in_idx == IDX_W'(i));
   end

   assign idx_ok = {1'b0, bus.in_idx} < N_LIM;

`ifdef DEC_ACK_EN
   assign hold_end = (cnt_q == '0) || bus.out_ack;
`else
   assign hold_end = (cnt_q == '0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         onehot_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         err_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  if (idx_ok) begin
                     onehot_q <= onehot_d;
                     valid_q  <= 1'b1;
                     busy_q   <= 1'b1;
                     cnt_q    <= HOLD_LD;
                     state_q  <= HOLD;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (hold_end) begin
                  onehot_q <= '0;
                  valid_q  <= 1'b0;
                  if (GAP_CYCLES == 0) begin
                     busy_q  <= 1'b0;
                     cnt_q   <= '0;
                     state_q <= IDLE;
                  end else begin
                     cnt_q   <= GAP_LD;
                     state_q <= GAP;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            GAP: begin
               if (cnt_q == '0) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q  <= IDLE;
               cnt_q    <= '0;
               onehot_q <= '0;
               valid_q  <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready   = (state_q == IDLE);
   assign bus.out_onehot = onehot_q;
   assign bus.out_valid  = valid_q;
   assign bus.busy       = busy_q;
   assign bus.idx_err    = err_q;
endmodule

// File: tb/tb_onehot_grant_decoder.sv
// Directed bench: default decoder plus an N_OUT=6 instance.
// Covers reset, grants, sweep, back-pressure, range error.
module tb_onehot_grant_decoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   onehot_grant_decoder_if #(.N_OUT(8), .IDX_W(3)) a_if ();
   onehot_grant_decoder_if #(.N_OUT(6), .IDX_W(3)) b_if ();

   onehot_grant_decoder #(
      .N_OUT(8), .IDX_W(3),
      .HOLD_CYCLES(4), .GAP_CYCLES(1)
   ) u_a (
      .clk(clk), .rst(rst), .bus(a_if.slave)
   );

   onehot_grant_decoder #(
      .N_OUT(6), .IDX_W(3),
      .HOLD_CYCLES(4), .GAP_CYCLES(1)
   ) u_b (
      .clk(clk), .rst(rst), .bus(b_if.slave)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h exp 0x%0h",
                  tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag,
                        input logic [7:0] oh,
                        input logic v,
                        input logic bz,
                        input logic rdy);
      check({tag, ".oh"}, 32'(a_if.out_onehot), 32'(oh));
      check({tag, ".v"}, 32'(a_if.out_valid), 32'(v));
      check({tag, ".busy"}, 32'(a_if.busy), 32'(bz));
      check({tag, ".rdy"}, 32'(a_if.in_ready), 32'(rdy));
   endtask

   initial begin
      logic [7:0] exp_oh;
      a_if.in_valid = 1'b0;
      a_if.in_idx   = '0;
      b_if.in_valid = 1'b0;
      b_if.in_idx   = '0;
`ifdef DEC_ACK_EN
      a_if.out_ack = 1'b0;
      b_if.out_ack = 1'b0;
`endif
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk_a("rst", 8'h00, 1'b0, 1'b0, 1'b1);
      check("rst.err", 32'(a_if.idx_err), 32'd0);
      check("rst.b_oh", 32'(b_if.out_onehot), 32'd0);

      // single grant, idx 5
      a_if.in_valid = 1'b1;
      a_if.in_idx   = 3'd5;
      tick();
      a_if.in_valid = 1'b0;
      chk_a("g5.h0", 8'h20, 1'b1, 1'b1, 1'b0);
      tick();
      chk_a("g5.h1", 8'h20, 1'b1, 1'b1, 1'b0);
      tick();
      chk_a("g5.h2", 8'h20, 1'b1, 1'b1, 1'b0);
      tick();
      chk_a("g5.h3", 8'h20, 1'b1, 1'b1, 1'b0);
      tick();
      chk_a("g5.gap", 8'h00, 1'b0, 1'b1, 1'b0);
      tick();
      chk_a("g5.idle", 8'h00, 1'b0, 1'b0, 1'b1);

      // sweep 0..7 with in_valid held
      a_if.in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a_if.in_idx = 3'(i);
         exp_oh = 8'h01 << i;
         check($sformatf("sw%0d.rdy", i),
               32'(a_if.in_ready), 32'd1);
         tick();
         for (int h = 0; h < 4; h++) begin
            check($sformatf("sw%0d.h%0d", i, h),
                  32'(a_if.out_onehot), 32'(exp_oh));
            check($sformatf("sw%0d.e%0d", i, h),
                  32'(a_if.idx_err), 32'd0);
            tick();
         end
         check($sformatf("sw%0d.gap", i),
               32'(a_if.out_onehot), 32'd0);
         tick();
      end

      // back-pressure: idx 2 waits behind idx 6
      a_if.in_idx = 3'd6;
      tick();
      a_if.in_idx = 3'd2;
      for (int h = 0; h < 4; h++) begin
         chk_a($sformatf("bp.h%0d", h),
               8'h40, 1'b1, 1'b1, 1'b0);
         tick();
      end
      chk_a("bp.gap", 8'h00, 1'b0, 1'b1, 1'b0);
      tick();
      chk_a("bp.idle", 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      a_if.in_valid = 1'b0;
      chk_a("bp.g2", 8'h04, 1'b1, 1'b1, 1'b0);
      repeat (5) tick();
      chk_a("bp.done", 8'h00, 1'b0, 1'b0, 1'b1);

      // reset two cycles into hold of idx 4
      a_if.in_valid = 1'b1;
      a_if.in_idx   = 3'd4;
      tick();
      a_if.in_valid = 1'b0;
      chk_a("mr.h0", 8'h10, 1'b1, 1'b1, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_a("mr.rst", 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      chk_a("mr.stay", 8'h00, 1'b0, 1'b0, 1'b1);

`ifdef DEC_ACK_EN
      a_if.in_valid = 1'b1;
      a_if.in_idx   = 3'd1;
      tick();
      a_if.in_valid = 1'b0;
      tick();
      chk_a("ack.h1", 8'h02, 1'b1, 1'b1, 1'b0);
      a_if.out_ack = 1'b1;
      tick();
      a_if.out_ack = 1'b0;
      chk_a("ack.gap", 8'h00, 1'b0, 1'b1, 1'b0);
      tick();
      chk_a("ack.idle", 8'h00, 1'b0, 1'b0, 1'b1);
`endif

      // N_OUT=6: idx 7 is out of range
      b_if.in_valid = 1'b1;
      b_if.in_idx   = 3'd7;
      tick();
      b_if.in_valid = 1'b0;
      check("re.err", 32'(b_if.idx_err), 32'd1);
      check("re.oh", 32'(b_if.out_onehot), 32'd0);
      check("re.rdy", 32'(b_if.in_ready), 32'd1);
      check("re.busy", 32'(b_if.busy), 32'd0);
      tick();
      check("re.err1", 32'(b_if.idx_err), 32'd0);
      b_if.in_valid = 1'b1;
      b_if.in_idx   = 3'd5;
      tick();
      b_if.in_valid = 1'b0;
      check("b5.oh", 32'(b_if.out_onehot), 32'h20);
      check("b5.err", 32'(b_if.idx_err), 32'd0);
      check("b5.v", 32'(b_if.out_valid), 32'd1);

      $display("[TB] %0d tests run, %0d failed",
               n_tests, n_fail);
      $finish;
   end
endmodule
